// File: rtl/seg_rr_arbiter_if.sv
// Request/grant/segment bundle between the requesters and the digit arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: none; requests are level-sensitive and held until granted.
interface seg_rr_arbiter_if;
  logic [7:0] in;     // request lines, bit i = requester i, active-high
  logic [7:0] grant;  // one-hot grant, zero when idle
  logic       busy;   // high while a grant is held
  logic [6:0] out;    // segments {g,f,e,d,c,b,a}, active-low

  // Requester / display side: drives requests, observes grant and segments.
  modport master (output in, input grant, input busy, input out);
  // Arbiter side.
  modport slave  (input in, output grant, output busy, output out);
endinterface

// File: rtl/seg_rr_arbiter.sv
// Round-robin arbiter sharing one 7-seg digit among 8 requesters; optional macro ARB_SHOW_LAST_EN keeps the last index on the digit while idle.
// Latency: a request sampled at an edge is granted at that same edge; at least one idle cycle separates grants.
// Backpressure: none; requesters hold their level until granted, holder is kept >= HOLD_CYCLES and preempted at MAX_CYCLES.
module seg_rr_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_CYCLES  = 16,
  parameter int CNT_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  seg_rr_arbiter_if.slave arb
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLES);
  localparam logic [6:0]       BLANK  = 7'b1111111;

  state_t           r_state;
  logic [7:0]       r_grant;
  logic             r_busy;
  logic [6:0]       r_out;
  logic [2:0]       r_ptr;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic       w_any;
  logic [2:0] w_sel;
  logic [7:0] w_others;
  logic       w_release;
  logic       w_preempt;

  // Active-low segment pattern for a channel index.
  function automatic logic [6:0] seg_code(input logic [2:0] idx);
    case (idx)
      3'd0:    seg_code = 7'b1000000;
      3'd1:    seg_code = 7'b1111001;
      3'd2:    seg_code = 7'b0100100;
      3'd3:    seg_code = 7'b0110000;
      3'd4:    seg_code = 7'b0011001;
      3'd5:    seg_code = 7'b0010010;
      3'd6:    seg_code = 7'b0000010;
      default: seg_code = 7'b1111000;
    endcase
  endfunction

  // Pick the first active request scanning upward from ptr, wrapping mod 8.
  always_comb begin
    logic [2:0] cand;
    logic       found;
    found = 1'b0;
    w_sel = r_ptr;
    cand  = r_ptr;
    for (int k = 0; k < 8; k++) begin
      cand = r_ptr + 3'(k);
      if (!found && arb.in[cand]) begin
        w_sel = cand;
        found = 1'b1;
      end
    end
    w_any = found;
  end

  // Release decisions use the registered dwell count of the current holder.
  assign w_others  = arb.in & ~(8'(1) << r_idx);
  assign w_release = (r_cnt >= HOLD_C) && !arb.in[r_idx];
  assign w_preempt = (r_cnt >= MAX_C) && (w_others != 8'd0);

  // Arbitration FSM with registered grant, busy and segment outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= 8'd0;
      r_busy  <= 1'b0;
      r_out   <= BLANK;
      r_ptr   <= 3'd0;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_idx   <= w_sel;
            r_grant <= 8'(1) << w_sel;
            r_busy  <= 1'b1;
            r_out   <= seg_code(w_sel);
            r_cnt   <= CNT_W'(1);
          end
        end
        S_GRANT: begin
          if (w_release || w_preempt) begin
            // Always fall back to idle; the next arbitration happens there,
            // with the released channel moved to lowest priority.
            r_state <= S_IDLE;
            r_grant <= 8'd0;
            r_busy  <= 1'b0;
`ifdef ARB_SHOW_LAST_EN
            r_out   <= r_out;
`else
            r_out   <= BLANK;
`endif
            r_cnt   <= '0;
            r_ptr   <= r_idx + 3'd1;
          end else if (r_cnt < MAX_C) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arb.grant = r_grant;
  assign arb.busy  = r_busy;
  assign arb.out   = r_out;

endmodule

// File: tb/tb_seg_rr_arbiter.sv
// Directed bench for seg_rr_arbiter with hand-computed grant/segment expectations.
// Latency: inputs change 1 time unit after a rising edge, outputs sampled 1 unit after the next one.
// Backpressure: none; all waits are fixed cycle counts.
module tb_seg_rr_arbiter;

  localparam logic [6:0] SEG0  = 7'b1000000;
  localparam logic [6:0] SEG2  = 7'b0100100;
  localparam logic [6:0] SEG5  = 7'b0010010;
  localparam logic [6:0] SEG6  = 7'b0000010;
  localparam logic [6:0] SEG7  = 7'b1111000;
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef ARB_SHOW_LAST_EN
  localparam logic [6:0] IDLE_AFTER_CH2 = SEG2;
`else
  localparam logic [6:0] IDLE_AFTER_CH2 = BLANK;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  seg_rr_arbiter_if arb_if ();

  seg_rr_arbiter #(
    .HOLD_CYCLES (4),
    .MAX_CYCLES  (16),
    .CNT_W       (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int cnt;

    // Reset held with every request line active.
    arb_if.in = 8'hFF;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_grant", 32'(arb_if.grant), 32'h00);
    chk("rst_busy",  32'(arb_if.busy),  32'h0);
    chk("rst_out",   32'(arb_if.out),   32'(BLANK));
    rst = 1'b0;
    tick();
    chk("first_grant", 32'(arb_if.grant), 32'h01);
    chk("first_out",   32'(arb_if.out),   32'(SEG0));
    chk("first_busy",  32'(arb_if.busy),  32'h1);
    arb_if.in = 8'h00;
    tick(); tick(); tick();
    chk("first_hold", 32'(arb_if.grant), 32'h01);
    tick();
    chk("first_rel", 32'(arb_if.grant), 32'h00);
    chk("first_rel_busy", 32'(arb_if.busy), 32'h0);

    // Single holder on channel 2; other requests toggling must not disturb it.
    arb_if.in = 8'h04;
    tick();
    chk("hold_grant", 32'(arb_if.grant), 32'h04);
    chk("hold_out",   32'(arb_if.out),   32'(SEG2));
    cnt = 1;
    for (int i = 1; i < 10; i++) begin
      arb_if.in = (i % 2 == 1) ? 8'h0C : 8'h04;
      tick();
      if (arb_if.grant == 8'h04 && arb_if.out == SEG2) cnt++;
    end
    chk("hold_cycles", 32'(cnt), 32'd10);
    arb_if.in = 8'h00;
    tick();
    chk("hold_rel_grant", 32'(arb_if.grant), 32'h00);
    chk("hold_rel_out",   32'(arb_if.out),   32'(IDLE_AFTER_CH2));

    // Short pulse on channel 5: held for exactly HOLD_CYCLES.
    arb_if.in = 8'h20;
    tick();
    chk("pulse_grant", 32'(arb_if.grant), 32'h20);
    chk("pulse_out",   32'(arb_if.out),   32'(SEG5));
    arb_if.in = 8'h00;
    cnt = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (arb_if.grant == 8'h20) cnt++;
    end
    tick();
    chk("pulse_cycles", 32'(cnt), 32'd4);
    chk("pulse_rel", 32'(arb_if.grant), 32'h00);
    // ptr should now be 6: with everyone requesting, channel 6 wins.
    arb_if.in = 8'hFF;
    tick();
    chk("pulse_ptr6", 32'(arb_if.grant), 32'h40);
    chk("pulse_ptr6_out", 32'(arb_if.out), 32'(SEG6));

    // Fairness between channels 0 and 7 from reset.
    rst = 1'b1;
    arb_if.in = 8'h81;
    tick();
    chk("fair_rst", 32'(arb_if.grant), 32'h00);
    rst = 1'b0;
    tick();
    chk("fair_g0", 32'(arb_if.grant), 32'h01);
    cnt = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (arb_if.grant == 8'h01) cnt++;
    end
    chk("fair_g0_len", 32'(cnt), 32'd16);
    tick();
    chk("fair_idle1", 32'(arb_if.grant), 32'h00);
    tick();
    chk("fair_g7", 32'(arb_if.grant), 32'h80);
    chk("fair_g7_out", 32'(arb_if.out), 32'(SEG7));
    cnt = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (arb_if.grant == 8'h80) cnt++;
    end
    chk("fair_g7_len", 32'(cnt), 32'd16);
    tick();
    chk("fair_idle2", 32'(arb_if.grant), 32'h00);
    tick();
    chk("fair_g0_again", 32'(arb_if.grant), 32'h01);

    // Saturation: lone requester keeps the grant well past MAX_CYCLES.
    rst = 1'b1;
    arb_if.in = 8'h08;
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (arb_if.grant == 8'h08 && arb_if.busy) cnt++;
    end
    chk("sat_len", 32'(cnt), 32'd40);
    arb_if.in = 8'h00;
    tick();
    chk("sat_rel", 32'(arb_if.grant), 32'h00);

    // Reset in the middle of a channel-6 grant at cnt=7.
    arb_if.in = 8'h40;
    tick();
    chk("mid_grant", 32'(arb_if.grant), 32'h40);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_grant_cnt7", 32'(arb_if.grant), 32'h40);
    rst = 1'b1;
    arb_if.in = 8'h41;
    tick();
    chk("mid_rst_grant", 32'(arb_if.grant), 32'h00);
    chk("mid_rst_out",   32'(arb_if.out),   32'(BLANK));
    chk("mid_rst_busy",  32'(arb_if.busy),  32'h0);
    rst = 1'b0;
    tick();
    chk("mid_next_grant", 32'(arb_if.grant), 32'h01);
    chk("mid_next_out",   32'(arb_if.out),   32'(SEG0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
